// File: rtl/ascii_line_writer_pkg.sv
// Shared constants and types for the ASCII line writer: byte codes, font range,
// writer FSM states and the byte classification used by the classifier.
package ascii_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] FONT_FIRST  = 8'd48;
    localparam logic [7:0] FONT_LAST   = 8'd90;
    localparam logic [7:0] LOWER_FIRST = 8'h61;
    localparam logic [7:0] LOWER_LAST  = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic {IDLE, CLEAR} lw_state_t;

    typedef enum {CLS_STORE, CLS_BS, CLS_CR, CLS_DROP} ascii_class_t;

endpackage

// File: rtl/ascii_line_writer_if.sv
// Valid/ready byte stream feeding the line writer.
interface ascii_line_writer_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/ascii_line_writer_classify.sv
// Combinational byte classifier: decides what an input byte does to the line and
// which renderer code it stores (lowercase folded to uppercase, space as blank).
module ascii_classify
    import ascii_pkg::*;
(
    input  logic [7:0]   in_data,
    output ascii_class_t cls,
    output logic [7:0]   code
);

    always_comb begin
        cls  = CLS_DROP;
        code = 8'd0;
        if (in_data >= FONT_FIRST && in_data <= FONT_LAST) begin
            cls  = CLS_STORE;
            code = in_data;
        end else if (in_data >= LOWER_FIRST && in_data <= LOWER_LAST) begin
            cls  = CLS_STORE;
            code = in_data - CASE_OFFSET;
        end else if (in_data == ASCII_SP) begin
            cls  = CLS_STORE;
            code = 8'd0;
        end else if (in_data == ASCII_BS) begin
            cls = CLS_BS;
        end else if (in_data == ASCII_CR) begin
            cls = CLS_CR;
        end
    end

endmodule

// File: rtl/ascii_line_writer.sv
// Writer side of the renderer's character line: takes bytes over valid/ready,
// edits the registered char array, and sweeps the line clear on CR.
module ascii_line_writer
    import ascii_pkg::*;
#(
    parameter int NUM_CHARS = 40,
    parameter bit WRAP_EN   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    ascii_line_writer_if.slave  stream,
    output logic [7:0]          char [0:NUM_CHARS],
    output logic [5:0]          cursor,
    output logic                full,
    output logic                overflow,
    output logic                busy
);

    localparam logic [5:0] LINE_END = 6'(NUM_CHARS);
    localparam logic [5:0] LAST_IDX = 6'(NUM_CHARS - 1);

    lw_state_t    state;
    lw_state_t    state_next;
    logic [5:0]   sweep_idx;
    logic         accept;
    logic         sweep_done;
    ascii_class_t cls;
    logic [7:0]   code;

    ascii_classify u_classify (
        .in_data (stream.in_data),
        .cls     (cls),
        .code    (code)
    );

    assign stream.in_ready = (state == IDLE);
    assign accept          = stream.in_valid && stream.in_ready;
    assign full            = (cursor == LINE_END);
    assign busy            = (state == CLEAR);
    assign sweep_done      = (sweep_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && cls == CLS_CR) state_next = CLEAR;
            CLEAR:   if (sweep_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Entry NUM_CHARS is only ever written by reset, so the renderer always reads 0 there.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_CHARS; i++) begin
                char[i] <= 8'd0;
            end
            cursor    <= 6'd0;
            overflow  <= 1'b0;
            sweep_idx <= 6'd0;
        end else begin
            overflow <= 1'b0;
            if (state == CLEAR) begin
                char[sweep_idx] <= 8'd0;
                if (sweep_done) begin
                    sweep_idx <= 6'd0;
                    cursor    <= 6'd0;
                end else begin
                    sweep_idx <= sweep_idx + 6'd1;
                end
            end else if (accept) begin
                case (cls)
                    CLS_STORE: begin
                        if (!full) begin
                            char[cursor] <= code;
                            cursor       <= cursor + 6'd1;
                        end else if (WRAP_EN) begin
                            char[0] <= code;
                            cursor  <= 6'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    CLS_BS: begin
                        if (cursor != 6'd0) begin
                            char[cursor - 6'd1] <= 8'd0;
                            cursor              <= cursor - 6'd1;
                        end
                    end
                    CLS_CR:  sweep_idx <= 6'd0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ascii_line_writer.sv
// Bench for ascii_line_writer: a no-wrap and a wrap instance driven in lockstep,
// checked against a byte-level line model.
module tb_ascii_line_writer;

    localparam int N = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascii_line_writer_if busA ();
    ascii_line_writer_if busB ();

    logic [7:0] charA [0:N];
    logic [7:0] charB [0:N];
    logic [5:0] cursorA, cursorB;
    logic       fullA, fullB, ovfA, ovfB, busyA, busyB;

    ascii_line_writer #(.NUM_CHARS(N), .WRAP_EN(1'b0)) dutA (
        .clk(clk), .rst(rst), .stream(busA), .char(charA), .cursor(cursorA),
        .full(fullA), .overflow(ovfA), .busy(busyA)
    );

    ascii_line_writer #(.NUM_CHARS(N), .WRAP_EN(1'b1)) dutB (
        .clk(clk), .rst(rst), .stream(busB), .char(charB), .cursor(cursorB),
        .full(fullB), .overflow(ovfB), .busy(busyB)
    );

    // Model state: index 0 mirrors the no-wrap instance, index 1 the wrap instance.
    int mLine [2][0:N];
    int mCursor [2];
    bit mOvf [2];
    int mClear;
    int total = 0;
    int bad = 0;

    function automatic int diffCount(input int k);
        int n = 0;
        for (int i = 0; i <= N; i++) begin
            if ((k == 0 ? charA[i] : charB[i]) !== 8'(mLine[k][i])) n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] expFlags();
        bit rdy;
        rdy = (mClear == 0);
        return {mCursor[0] == N, mCursor[1] == N, mOvf[0], mOvf[1], !rdy, !rdy, rdy, rdy};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i <= N; i++) mLine[k][i] = 0;
            mCursor[k] = 0;
            mOvf[k] = 1'b0;
        end
        mClear = 0;
    endtask

    task automatic modelByte(input logic [7:0] d);
        int code;
        bit store;
        store = 1'b0;
        code = 0;
        if (d >= 48 && d <= 90) begin
            store = 1'b1; code = int'(d);
        end else if (d >= 97 && d <= 122) begin
            store = 1'b1; code = int'(d) - 32;
        end else if (d == 32) begin
            store = 1'b1; code = 0;
        end
        for (int k = 0; k < 2; k++) begin
            if (store) begin
                if (mCursor[k] < N) begin
                    mLine[k][mCursor[k]] = code;
                    mCursor[k]++;
                end else if (k == 1) begin
                    mLine[k][0] = code;
                    mCursor[k] = 1;
                end else begin
                    mOvf[k] = 1'b1;
                end
            end else if (d == 8 && mCursor[k] > 0) begin
                mCursor[k]--;
                mLine[k][mCursor[k]] = 0;
            end
        end
        if (d == 13) mClear = N;
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge,
    // return 1 time unit later so the caller samples settled outputs.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = r;
        busA.in_valid = v; busA.in_data = d;
        busB.in_valid = v; busB.in_data = d;
        @(posedge clk);
        mOvf[0] = 1'b0;
        mOvf[1] = 1'b0;
        if (r) begin
            modelReset();
        end else if (mClear > 0) begin
            mClear--;
            if (mClear == 0) begin
                for (int k = 0; k < 2; k++) begin
                    for (int i = 0; i <= N; i++) mLine[k][i] = 0;
                    mCursor[k] = 0;
                end
            end
        end else if (v) begin
            modelByte(d);
        end
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h41);
        applyStimulus(1'b0, 1'b0, 8'h00);
        total++;
        if ({cursorA, cursorB} !== 12'd0) begin
            bad++; $display("[TB] FAIL reset_cursor: got %0d/%0d want 0/0", cursorA, cursorB);
        end
        total++;
        if ({fullA, fullB, ovfA, ovfB, busyA, busyB, busA.in_ready, busB.in_ready} !== 8'b00000011) begin
            bad++; $display("[TB] FAIL reset_flags: got %b want 00000011",
                {fullA, fullB, ovfA, ovfB, busyA, busyB, busA.in_ready, busB.in_ready});
        end
        total++;
        if (diffCount(0) + diffCount(1) !== 0) begin
            bad++; $display("[TB] FAIL reset_line: got %0d nonzero entries want 0", diffCount(0) + diffCount(1));
        end
    endtask

    task automatic test_store();
        logic [7:0] msg [3] = '{8'h41, 8'h42, 8'h31};
        int notReady = 0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        foreach (msg[i]) begin
            applyStimulus(1'b0, 1'b1, msg[i]);
            if (busA.in_ready !== 1'b1) notReady++;
        end
        total++;
        if ({charA[0], charA[1], charA[2]} !== {8'd65, 8'd66, 8'd49}) begin
            bad++; $display("[TB] FAIL store_ab1: got %0d,%0d,%0d want 65,66,49", charA[0], charA[1], charA[2]);
        end
        total++;
        if (cursorA !== 6'd3 || notReady !== 0) begin
            bad++; $display("[TB] FAIL store_cursor: got cursor %0d stalls %0d want 3 and 0", cursorA, notReady);
        end
        total++;
        if (diffCount(0) !== 0) begin
            bad++; $display("[TB] FAIL store_rest: got %0d wrong entries want 0", diffCount(0));
        end
    endtask

    task automatic test_case_and_backspace();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h61);
        applyStimulus(1'b0, 1'b1, 8'h20);
        applyStimulus(1'b0, 1'b1, 8'h7A);
        total++;
        if ({charA[0], charA[1], charA[2], 2'b00, cursorA} !== {8'd65, 8'd0, 8'd90, 8'd3}) begin
            bad++; $display("[TB] FAIL case_fold: got %0d,%0d,%0d cur %0d want 65,0,90 cur 3",
                charA[0], charA[1], charA[2], cursorA);
        end
        applyStimulus(1'b0, 1'b1, 8'h08);
        total++;
        if (charA[2] !== 8'd0 || cursorA !== 6'd2) begin
            bad++; $display("[TB] FAIL bs_one: got char2 %0d cur %0d want 0 cur 2", charA[2], cursorA);
        end
        repeat (3) applyStimulus(1'b0, 1'b1, 8'h08);
        total++;
        if (cursorA !== 6'd0 || ovfA !== 1'b0 || diffCount(0) !== 0) begin
            bad++; $display("[TB] FAIL bs_floor: got cur %0d ovf %0b diffs %0d want 0 0 0", cursorA, ovfA, diffCount(0));
        end
    endtask

    task automatic test_full_line();
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (N) applyStimulus(1'b0, 1'b1, 8'h58);
        total++;
        if ({fullA, fullB, ovfA} !== 3'b110) begin
            bad++; $display("[TB] FAIL full_flag: got %b want 110", {fullA, fullB, ovfA});
        end
        applyStimulus(1'b0, 1'b1, 8'h59);
        total++;
        if (ovfA !== 1'b1 || cursorA !== 6'd40 || charA[39] !== 8'd88 || charA[40] !== 8'd0) begin
            bad++; $display("[TB] FAIL overflow_drop: got ovf %0b cur %0d c39 %0d c40 %0d want 1 40 88 0",
                ovfA, cursorA, charA[39], charA[40]);
        end
        total++;
        if (charB[0] !== 8'd89 || cursorB !== 6'd1 || ovfB !== 1'b0) begin
            bad++; $display("[TB] FAIL wrap_store: got c0 %0d cur %0d ovf %0b want 89 1 0", charB[0], cursorB, ovfB);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        total++;
        if (ovfA !== 1'b0 || diffCount(0) + diffCount(1) !== 0) begin
            bad++; $display("[TB] FAIL overflow_pulse: got ovf %0b diffs %0d want 0 0", ovfA, diffCount(0) + diffCount(1));
        end
    endtask

    task automatic test_clear();
        int busyCycles;
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(65 + $urandom_range(0, 25)));
        applyStimulus(1'b0, 1'b1, 8'h0D);
        busyCycles = (busyA === 1'b1 && busA.in_ready === 1'b0) ? 1 : 0;
        for (int c = 0; c < 60 && busyA === 1'b1; c++) begin
            applyStimulus(1'b0, 1'b1, 8'h51);
            if (busyA === 1'b1 && busA.in_ready === 1'b0) busyCycles++;
        end
        total++;
        if (busyCycles !== 40) begin
            bad++; $display("[TB] FAIL clear_length: got %0d busy cycles want 40", busyCycles);
        end
        total++;
        if (cursorA !== 6'd0 || busA.in_ready !== 1'b1 || diffCount(0) + diffCount(1) !== 0) begin
            bad++; $display("[TB] FAIL clear_result: got cur %0d rdy %0b diffs %0d want 0 1 0",
                cursorA, busA.in_ready, diffCount(0) + diffCount(1));
        end
    endtask

    task automatic test_reset_mid_clear();
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(72 + i));
        applyStimulus(1'b0, 1'b1, 8'h0D);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        total++;
        if (busyA !== 1'b0 || busA.in_ready !== 1'b1 || diffCount(0) + diffCount(1) !== 0) begin
            bad++; $display("[TB] FAIL midclear_reset: got busy %0b rdy %0b diffs %0d want 0 1 0",
                busyA, busA.in_ready, diffCount(0) + diffCount(1));
        end
        applyStimulus(1'b0, 1'b1, 8'h51);
        total++;
        if (charA[0] !== 8'd81 || cursorA !== 6'd1) begin
            bad++; $display("[TB] FAIL midclear_next: got c0 %0d cur %0d want 81 1", charA[0], cursorA);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] d;
        int         r;
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 800; c++) begin
            v = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 40)      d = 8'(65 + $urandom_range(0, 25));
            else if (r < 55) d = 8'(97 + $urandom_range(0, 25));
            else if (r < 65) d = 8'(48 + $urandom_range(0, 9));
            else if (r < 72) d = 8'h20;
            else if (r < 82) d = 8'h08;
            else if (r < 84) d = 8'h0D;
            else             d = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, v, d);
            total++;
            if ({cursorA, cursorB} !== {6'(mCursor[0]), 6'(mCursor[1])}) begin
                bad++; $display("[TB] FAIL rand_cursor @%0d: got %0d/%0d want %0d/%0d",
                    c, cursorA, cursorB, mCursor[0], mCursor[1]);
            end
            total++;
            if ({fullA, fullB, ovfA, ovfB, busyA, busyB, busA.in_ready, busB.in_ready} !== expFlags()) begin
                bad++; $display("[TB] FAIL rand_flags @%0d: got %b want %b", c,
                    {fullA, fullB, ovfA, ovfB, busyA, busyB, busA.in_ready, busB.in_ready}, expFlags());
            end
            if (mClear == 0) begin
                total++;
                if (diffCount(0) + diffCount(1) !== 0) begin
                    bad++; $display("[TB] FAIL rand_line @%0d: got %0d wrong entries want 0",
                        c, diffCount(0) + diffCount(1));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        busA.in_valid = 1'b0; busA.in_data = 8'h00;
        busB.in_valid = 1'b0; busB.in_data = 8'h00;
        modelReset();
        test_reset();
        test_store();
        test_case_and_backspace();
        test_full_line();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
